// File: rtl/identifier_quarter.sv
// CORDIC angle pre-processor: wraps a sign-magnitude degree angle into [0,360) and returns quadrant + residual.
// Build option IDENTIFIER_QUARTER_MIRROR_EN: quadrants 01/11 report the residual measured from the next axis.
module identifier_quarter #(
  parameter int DATA_WIDTH = 20,
  parameter int PHI_WIDTH  = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [PHI_WIDTH-1:0] phi_veer_in,
  output logic [PHI_WIDTH-1:0] phi_veer_out,
  output logic [1:0]           quarter,
  output logic                 done
);

  localparam int MW = PHI_WIDTH - 1;
  localparam logic [MW-1:0] C90  = MW'(90  << 12);
  localparam logic [MW-1:0] C180 = MW'(180 << 12);
  localparam logic [MW-1:0] C270 = MW'(270 << 12);
  localparam logic [MW-1:0] C360 = MW'(360 << 12);

  // The magnitude field must hold at least 9 integer bits to represent 360.
  if (PHI_WIDTH < 22 || DATA_WIDTH < 1) begin : g_param_check
    $error("identifier_quarter: PHI_WIDTH must be >= 22 and DATA_WIDTH >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WRAP = 3'd2,
    S_SIGN = 3'd3,
    S_QUAD = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_capture;
  logic            w_wrap;
  logic            w_sign;
  logic            w_quad;

  logic            r_s;
  logic [MW-1:0]   r_m;
  logic [MW-1:0]   r_out;
  logic [1:0]      r_quarter;
  logic            r_done;

  logic            w_ge90;
  logic            w_ge180;
  logic            w_ge270;
  logic [1:0]      w_q;
  logic [MW-1:0]   w_base;
  logic [MW-1:0]   w_res;
  logic [MW-1:0]   w_out_m;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_next = S_LOAD;
      S_LOAD:  w_next = S_WRAP;
      S_WRAP:  w_next = S_SIGN;
      S_SIGN:  w_next = S_QUAD;
      S_QUAD:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_capture = 1'b0;
    w_wrap    = 1'b0;
    w_sign    = 1'b0;
    w_quad    = 1'b0;
    case (r_state)
      S_IDLE:  w_capture = enable;
      S_WRAP:  w_wrap    = 1'b1;
      S_SIGN:  w_sign    = 1'b1;
      S_QUAD:  w_quad    = 1'b1;
      default: ;
    endcase
  end

  // Thresholds are ordered, so the count of crossed thresholds is the quadrant.
  always_comb begin
    w_ge90  = (r_m >= C90);
    w_ge180 = (r_m >= C180);
    w_ge270 = (r_m >= C270);
    w_q     = {1'b0, w_ge90} + {1'b0, w_ge180} + {1'b0, w_ge270};
    case (w_q)
      2'd0:    w_base = '0;
      2'd1:    w_base = C90;
      2'd2:    w_base = C180;
      default: w_base = C270;
    endcase
    w_res = r_m - w_base;
`ifdef IDENTIFIER_QUARTER_MIRROR_EN
    w_out_m = w_q[0] ? (C90 - w_res) : w_res;
`else
    w_out_m = w_res;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s       <= 1'b0;
      r_m       <= '0;
      r_out     <= '0;
      r_quarter <= 2'd0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_quad;
      if (w_capture) begin
        r_s <= phi_veer_in[PHI_WIDTH-1];
        r_m <= phi_veer_in[MW-1:0];
      end
      // Inputs stay below 720 degrees, so a single subtraction wraps fully.
      if (w_wrap && (r_m >= C360)) r_m <= r_m - C360;
      if (w_sign && r_s && (r_m != '0)) r_m <= C360 - r_m;
      if (w_quad) begin
        r_quarter <= w_q;
        r_out     <= w_out_m;
      end
    end
  end

  assign phi_veer_out = {1'b0, r_out};
  assign quarter      = r_quarter;
  assign done         = r_done;

endmodule

// File: tb/tb_identifier_quarter.sv
// Directed bench for identifier_quarter (default build): latency, quadrant, residual, wrap and reset abort.
module tb_identifier_quarter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [21:0] phi_in;
  logic [21:0] phi_out;
  logic [1:0]  quarter;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  identifier_quarter #(.DATA_WIDTH(20), .PHI_WIDTH(22)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .phi_veer_in  (phi_in),
    .phi_veer_out (phi_out),
    .quarter      (quarter),
    .done         (done)
  );

  function automatic logic [21:0] ang(input logic s, input int ip, input int fr);
    return {s, 9'(ip), 12'(fr)};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start one operation and check latency, result and the single-cycle done pulse.
  task automatic run_op(input string tag, input logic [21:0] phi, input logic [1:0] eq,
                        input logic [21:0] eo, input bit noise);
    int cyc;
    @(negedge clk);
    phi_in = phi;
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    cyc = 0;
    while (cyc < 8 && done !== 1'b1) begin
      @(posedge clk);
      #1;
      cyc++;
      if (noise && done !== 1'b1) begin
        enable = cyc[0];
        phi_in = ang(1'b0, 300, 5);
      end
    end
    enable = 1'b0;
    check_val({tag, " latency"}, cyc, 4);
    check_val({tag, " quarter"}, {30'd0, quarter}, {30'd0, eq});
    check_val({tag, " out"}, {10'd0, phi_out}, {10'd0, eo});
    @(posedge clk);
    #1;
    check_val({tag, " done pulse"}, {31'd0, done}, 32'd0);
    check_val({tag, " out hold"}, {10'd0, phi_out}, {10'd0, eo});
  endtask

  initial begin
    int first_done;
    int second_done;
    int n_done;
    rst    = 1'b0;
    enable = 1'b0;
    phi_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset done", {31'd0, done}, 32'd0);
    check_val("reset quarter", {30'd0, quarter}, 32'd0);
    check_val("reset out", {10'd0, phi_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("p55",      ang(0, 55, 0),      2'd0, ang(0, 55, 0), 1'b0);
    run_op("n55",      ang(1, 55, 0),      2'd3, ang(0, 35, 0), 1'b0);
    run_op("n95",      ang(1, 95, 2),      2'd2, ang(0, 84, 'hFFE), 1'b0);
    run_op("p90",      ang(0, 90, 0),      2'd1, ang(0, 0, 0), 1'b0);
    run_op("p180",     ang(0, 180, 0),     2'd2, ang(0, 0, 0), 1'b0);
    run_op("p270",     ang(0, 270, 0),     2'd3, ang(0, 0, 0), 1'b0);
    run_op("p360",     ang(0, 360, 0),     2'd0, ang(0, 0, 0), 1'b0);
    run_op("nzero",    ang(1, 0, 0),       2'd0, ang(0, 0, 0), 1'b0);
    run_op("n360",     ang(1, 360, 0),     2'd0, ang(0, 0, 0), 1'b0);
    run_op("p450.5",   ang(0, 450, 'h800), 2'd1, ang(0, 0, 'h800), 1'b0);
    run_op("p359.99",  ang(0, 359, 'hFFF), 2'd3, ang(0, 89, 'hFFF), 1'b0);
    run_op("p89.99",   ang(0, 89, 'hFFF),  2'd0, ang(0, 89, 'hFFF), 1'b0);
    run_op("n180",     ang(1, 180, 0),     2'd2, ang(0, 0, 0), 1'b0);
    run_op("n270.25",  ang(1, 270, 'h400), 2'd0, ang(0, 89, 'hC00), 1'b1);
    run_op("n55b",     ang(1, 55, 0),      2'd3, ang(0, 35, 0), 1'b0);

    // Abort an operation while it sits in WRAP.
    @(negedge clk);
    phi_in = ang(0, 200, 0);
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("abort done", {31'd0, done}, 32'd0);
    check_val("abort quarter", {30'd0, quarter}, 32'd0);
    check_val("abort out", {10'd0, phi_out}, 32'd0);
    n_done = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    rst = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    check_val("abort no done", n_done, 0);
    check_val("abort out held0", {10'd0, phi_out}, 32'd0);

    run_op("post rst", ang(1, 95, 2), 2'd2, ang(0, 84, 'hFFE), 1'b0);

    // Enable held high: one result every 5 cycles.
    @(negedge clk);
    phi_in = ang(0, 100, 0);
    enable = 1'b1;
    @(posedge clk);
    #1;
    first_done  = -1;
    second_done = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
    end
    enable = 1'b0;
    check_val("hold first done", first_done, 4);
    check_val("hold second done", second_done, 9);
    check_val("hold quarter", {30'd0, quarter}, 32'd1);
    check_val("hold out", {10'd0, phi_out}, {10'd0, ang(0, 10, 0)});
    repeat (8) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
